fetch_unit: RTL and testbench

- Instruction-fetch stage that owns the PC and sits directly upstream of decode/execute in the MIPS datapath.
- Issues one word fetch at a time to a variable-latency instruction memory over a request/response handshake.
- Buffers the returned word and presents it to decode with valid/ready, together with its PC and PC+4.
- Accepts branch/jump redirects from execute, squashes stale fetches, and supports a sticky halt.

---
 rtl/mips_fetch_pkg.sv | 23 ++
 rtl/fetch_unit_add4.sv | 14 +
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

    // Fetch sequencing states.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetchState_e;

    // Bytes per instruction word; also the sequential PC increment.
    localparam int INSTR_BYTES = 4;

    // Default PC loaded on reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Clear the byte-offset bits of an address so it lands on a word boundary.
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_add4.sv
// PC incrementer: adds one instruction width, wrapping modulo 2^WIDTH.
module Add4
    import mips_fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Plain modular add; the carry out of the top bit is intentionally dropped.
    assign y = a + WIDTH'(INSTR_BYTES);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time to a
// variable-latency instruction memory, buffers the returned word for decode,
// and handles redirects from execute plus a sticky halt.
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc_plus4,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              halted,
    output logic              err_misaligned
);

    fetchState_e       stateReg, stateNext;
    logic [ADDR_W-1:0] pcReg, pcNext;
    logic              squashReg, squashNext;
    logic              haltPendReg, haltPendNext;
    logic              errReg, errNext;
    logic [DATA_W-1:0] instDataReg;
    logic [ADDR_W-1:0] instPcReg;
    logic [ADDR_W-1:0] instPcPlus4Reg;

    logic              loadInst;
    logic              reqValid;
    logic [ADDR_W-1:0] pcPlus4;
    logic [ADDR_W-1:0] redirectAligned;
    logic              redirectMisaligned;

    Add4 #(
        .WIDTH (ADDR_W)
    ) pcAdder (
        .a (pcReg),
        .y (pcPlus4)
    );

    // Redirect targets are always forced onto a word boundary.
    assign redirectAligned    = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign redirectMisaligned = |redirect_pc[1:0];

    // Next-state and control decode for the fetch sequencer.
    always_comb begin
        stateNext    = stateReg;
        pcNext       = pcReg;
        squashNext   = squashReg;
        haltPendNext = haltPendReg | halt;
        errNext      = errReg;
        loadInst     = 1'b0;
        reqValid     = 1'b0;

        case (stateReg)
            S_REQ: begin
                if (haltPendReg) begin
                    // Halt takes effect here, before any new request goes out.
                    stateNext = S_HALT;
                end else begin
                    reqValid = 1'b1;
                    if (redirect_valid) begin
                        pcNext  = redirectAligned;
                        errNext = errReg | redirectMisaligned;
                    end
                    if (imem_req_ready) begin
                        stateNext = S_WAIT;
                        // The request just accepted carries the old PC.
                        if (redirect_valid) begin
                            squashNext = 1'b1;
                        end
                    end
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pcNext  = redirectAligned;
                    errNext = errReg | redirectMisaligned;
                    if (imem_resp_valid) begin
                        // Stale word arrives with the redirect: drop it now.
                        squashNext = 1'b0;
                        stateNext  = S_REQ;
                    end else begin
                        squashNext = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (squashReg) begin
                        squashNext = 1'b0;
                        stateNext  = S_REQ;
                    end else begin
                        loadInst  = 1'b1;
                        stateNext = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    // Word is consumed if ready, otherwise dropped; either way
                    // the PC follows the redirect.
                    pcNext    = redirectAligned;
                    errNext   = errReg | redirectMisaligned;
                    stateNext = S_REQ;
                end else if (inst_ready) begin
                    pcNext    = pcPlus4;
                    stateNext = S_REQ;
                end
            end

            S_HALT: begin
                stateNext = S_HALT;
            end

            default: begin
                stateNext = S_REQ;
            end
        endcase
    end

    // State, PC, flags and the decode-facing instruction buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg       <= S_REQ;
            pcReg          <= RESET_PC;
            squashReg      <= 1'b0;
            haltPendReg    <= 1'b0;
            errReg         <= 1'b0;
            instDataReg    <= '0;
            instPcReg      <= '0;
            instPcPlus4Reg <= '0;
        end else begin
            stateReg    <= stateNext;
            pcReg       <= pcNext;
            squashReg   <= squashNext;
            haltPendReg <= haltPendNext;
            errReg      <= errNext;
            if (loadInst) begin
                instDataReg    <= imem_resp_data;
                instPcReg      <= pcReg;
                instPcPlus4Reg <= pcPlus4;
            end
        end
    end

    // No request may be issued while reset is held.
    assign imem_req_valid = reqValid & ~reset;
    assign imem_req_addr  = pcReg;
    assign inst_valid     = (stateReg == S_HOLD);
    assign inst_data      = instDataReg;
    assign inst_pc        = instPcReg;
    assign inst_pc_plus4  = instPcPlus4Reg;
    assign halted         = (stateReg == S_HALT);
    assign err_misaligned = errReg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a cycle-stepped instruction memory.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic        err_misaligned;

    int          total = 0;
    int          bad   = 0;

    // Memory model state
    int          memLat = 1;
    int          memWait = 0;
    logic        memBusy = 1'b0;
    logic [31:0] memAddr = 32'h0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32),
        .DATA_W   (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_pc_plus4   (inst_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .halted          (halted),
        .err_misaligned  (err_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'h0: return 32'h2001_000A;
            32'h4: return 32'h2002_0005;
            32'h8: return 32'h0022_1820;
            default: return ~addr;
        endcase
    endfunction

    // Advance one clock; the memory answers memLat cycles after acceptance.
    task automatic step();
        logic        acc;
        logic        del;
        logic [31:0] a;
        #1;
        acc = imem_req_valid && imem_req_ready;
        del = imem_resp_valid;
        a   = imem_req_addr;
        @(posedge clk);
        if (del) memBusy = 1'b0;
        if (acc) begin
            memBusy = 1'b1;
            memWait = memLat - 1;
            memAddr = a;
        end
        if (reset) memBusy = 1'b0;
        @(negedge clk);
        if (memBusy && memWait == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = rom(memAddr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
            if (memBusy) memWait--;
        end
        #1;
    endtask

    task automatic doReset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        inst_ready = 1'b0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        redirect_pc = 32'h0;
        reset = 1'b1;
        redirect_valid = 1'b0;
        halt = 1'b0;
        step();
        step();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
        total++; if (inst_data !== 32'h0) begin bad++; $display("FAIL rst_inst_data got=%h exp=0", inst_data); end
        total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
        total++; if (inst_pc_plus4 !== 32'h0) begin bad++; $display("FAIL rst_pc_plus4 got=%h exp=0", inst_pc_plus4); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
        total++; if (err_misaligned !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_misaligned); end
        reset = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_first_req got=%b/%h exp=1/0", imem_req_valid, imem_req_addr); end
        $display("test_reset done");
    endtask

    // Three sequential fetches, one instruction every three cycles.
    task automatic test_sequential();
        logic [31:0] words [3];
        logic        expValid, expReq;
        int          idx;
        words[0] = 32'h2001_000A;
        words[1] = 32'h2002_0005;
        words[2] = 32'h0022_1820;
        memLat = 1;
        inst_ready = 1'b1;
        doReset();
        for (int c = 1; c <= 9; c++) begin
            expValid = (c % 3 == 0);
            expReq   = (c % 3 == 1);
            total++; if (inst_valid !== expValid) begin bad++; $display("FAIL seq_valid c=%0d got=%b exp=%b", c, inst_valid, expValid); end
            if (expValid) begin
                idx = c / 3 - 1;
                total++; if (inst_pc !== 32'(idx * 4)) begin bad++; $display("FAIL seq_pc c=%0d got=%h exp=%h", c, inst_pc, idx * 4); end
                total++; if (inst_data !== words[idx]) begin bad++; $display("FAIL seq_data c=%0d got=%h exp=%h", c, inst_data, words[idx]); end
                total++; if (inst_pc_plus4 !== 32'(idx * 4 + 4)) begin bad++; $display("FAIL seq_plus4 c=%0d got=%h exp=%h", c, inst_pc_plus4, idx * 4 + 4); end
            end
            total++; if (imem_req_valid !== expReq) begin bad++; $display("FAIL seq_req c=%0d got=%b exp=%b", c, imem_req_valid, expReq); end
            if (expReq) begin
                total++; if (imem_req_addr !== 32'(((c - 1) / 3) * 4)) begin bad++; $display("FAIL seq_addr c=%0d got=%h exp=%h", c, imem_req_addr, ((c - 1) / 3) * 4); end
            end
            step();
        end
        $display("test_sequential done");
    endtask

    task automatic test_backpressure();
        memLat = 1;
        inst_ready = 1'b0;
        doReset();
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h2001_000A) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%h/%h exp=1/0/2001000a", c, inst_valid, inst_pc, inst_data); end
            total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_noreq c=%0d got=%b exp=0", c, imem_req_valid); end
            step();
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL bp_after_valid got=%b exp=0", inst_valid); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin bad++; $display("FAIL bp_next_req got=%b/%h exp=1/4", imem_req_valid, imem_req_addr); end
        $display("test_backpressure done");
    endtask

    task automatic test_redirect_wait();
        memLat = 2;
        inst_ready = 1'b1;
        doReset();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        total++; if (imem_resp_valid !== 1'b1) begin bad++; $display("FAIL rw_stale_resp got=%b exp=1", imem_resp_valid); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rw_stale_valid got=%b exp=0", inst_valid); end
        step();
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rw_squash_valid got=%b exp=0", inst_valid); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin bad++; $display("FAIL rw_req got=%b/%h exp=1/40", imem_req_valid, imem_req_addr); end
        step();
        for (int c = 0; c < 2; c++) begin
            total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rw_wait_valid c=%0d got=%b exp=0", c, inst_valid); end
            step();
        end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst_data !== 32'hFFFF_FFBF || inst_pc_plus4 !== 32'h44) begin bad++; $display("FAIL rw_inst got=%b/%h/%h/%h exp=1/40/ffffffbf/44", inst_valid, inst_pc, inst_data, inst_pc_plus4); end
        memLat = 1;
        $display("test_redirect_wait done");
    endtask

    task automatic test_redirect_drop();
        memLat = 1;
        inst_ready = 1'b0;
        doReset();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rd_coinc_valid got=%b exp=0", inst_valid); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin bad++; $display("FAIL rd_coinc_req got=%b/%h exp=1/100", imem_req_valid, imem_req_addr); end
        step();
        step();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin bad++; $display("FAIL rd_hold got=%b/%h exp=1/100", inst_valid, inst_pc); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rd_drop_valid got=%b exp=0", inst_valid); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin bad++; $display("FAIL rd_drop_req got=%b/%h exp=1/200", imem_req_valid, imem_req_addr); end
        step();
        step();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst_data !== 32'hFFFF_FDFF) begin bad++; $display("FAIL rd_new got=%b/%h/%h exp=1/200/fffffdff", inst_valid, inst_pc, inst_data); end
        $display("test_redirect_drop done");
    endtask

    task automatic test_wrap_misaligned();
        memLat = 1;
        inst_ready = 1'b1;
        doReset();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        total++; if (err_misaligned !== 1'b0) begin bad++; $display("FAIL wm_err_before got=%b exp=0", err_misaligned); end
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wm_req got=%b/%h exp=1/fffffffc", imem_req_valid, imem_req_addr); end
        total++; if (err_misaligned !== 1'b1) begin bad++; $display("FAIL wm_err got=%b exp=1", err_misaligned); end
        step();
        step();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_pc_plus4 !== 32'h0 || inst_data !== 32'h0000_0003) begin bad++; $display("FAIL wm_inst got=%b/%h/%h/%h exp=1/fffffffc/0/3", inst_valid, inst_pc, inst_pc_plus4, inst_data); end
        step();
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL wm_wrap_req got=%b/%h exp=1/0", imem_req_valid, imem_req_addr); end
        total++; if (err_misaligned !== 1'b1) begin bad++; $display("FAIL wm_err_sticky got=%b exp=1", err_misaligned); end
        $display("test_wrap_misaligned done");
    endtask

    task automatic test_halt();
        memLat = 2;
        inst_ready = 1'b0;
        doReset();
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        step();
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h2001_000A) begin bad++; $display("FAIL ht_deliver got=%b/%h/%h exp=1/0/2001000a", inst_valid, inst_pc, inst_data); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL ht_early got=%b exp=0", halted); end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL ht_noreq got=%b exp=0", imem_req_valid); end
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++; if (halted !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL ht_stay c=%0d got=%b/%b/%b exp=1/0/0", c, halted, imem_req_valid, inst_valid); end
            step();
        end
        memLat = 1;
        doReset();
        total++; if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL ht_reset got=%b/%b/%h exp=0/1/0", halted, imem_req_valid, imem_req_addr); end
        $display("test_halt done");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_drop();
        test_wrap_misaligned();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
